// File: rtl/bus_pkg.sv
// Shared types and constants for the round-robin bus arbiter.
// Optional grant watchdog in bus_rr_arbiter is enabled with `define ARB_TIMEOUT_EN.
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } arb_state_t;

  localparam int DEF_NUM_MASTERS = 4;
  localparam int DEF_NUM_SLAVES  = 3;
  localparam int DEF_MAX_HOLD    = 256;

  // Index width for n items; a single item still needs one select bit.
  function automatic int sel_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotate-priority encoder: first set request after index 'last',
// wrapping modulo N.
module rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last,
  output logic [W-1:0] winner,
  output logic         valid
);

  always_comb begin
    int idx;
    logic [W-1:0] sel;
    idx    = 0;
    sel    = '0;
    winner = '0;
    valid  = 1'b0;
    // Scan last+1 .. last+N so the previous owner is checked last.
    for (int k = 1; k <= N; k++) begin
      idx = (int'(last) + k) % N;
      sel = W'(idx);
      if (!valid && req[sel]) begin
        valid  = 1'b1;
        winner = sel;
      end
    end
  end

endmodule

// File: rtl/bus_rr_arbiter.sv
// Round-robin arbiter for the shared serial bus; grants only when all slaves are ready.
// Define ARB_TIMEOUT_EN to add the MAX_HOLD grant watchdog and per-master mask.
module bus_rr_arbiter
  import bus_pkg::*;
#(
  parameter int NUM_MASTERS = DEF_NUM_MASTERS,
  parameter int NUM_SLAVES  = DEF_NUM_SLAVES,
  parameter int MSEL_W      = 2,
  parameter int MAX_HOLD    = DEF_MAX_HOLD
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [NUM_MASTERS-1:0] breq,
  input  logic [NUM_SLAVES-1:0]  sready,
  output logic [NUM_MASTERS-1:0] bgrant,
  output logic [MSEL_W-1:0]      msel,
  output logic                   bus_busy,
  output logic                   timeout
);

  if (MSEL_W != sel_width(NUM_MASTERS)) begin : g_bad_msel_w
    $error("bus_rr_arbiter: MSEL_W must equal max(1, clog2(NUM_MASTERS))");
  end
  if (MAX_HOLD < 1) begin : g_bad_max_hold
    $error("bus_rr_arbiter: MAX_HOLD must be at least 1");
  end

  localparam logic [MSEL_W-1:0] LAST_RST = MSEL_W'(NUM_MASTERS - 1);

  arb_state_t               state, state_nx;
  logic [NUM_MASTERS-1:0]   bgrant_nx;
  logic [MSEL_W-1:0]        msel_nx;
  logic                     busy_nx;
  logic [MSEL_W-1:0]        last, last_nx;
  logic [NUM_MASTERS-1:0]   pick_req;
  logic [MSEL_W-1:0]        pick_winner;
  logic                     pick_valid;
  logic                     all_ready;
  logic                     owner_req;

  assign all_ready = &sready;
  assign owner_req = breq[msel];

`ifdef ARB_TIMEOUT_EN
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  logic [HOLD_W-1:0]      hold_cnt, hold_nx;
  logic [NUM_MASTERS-1:0] mask, mask_nx;
  logic                   timeout_nx;

  assign pick_req = breq & ~mask;
`else
  assign pick_req = breq;
  assign timeout  = 1'b0;
`endif

  rr_pick #(
    .N (NUM_MASTERS),
    .W (MSEL_W)
  ) u_pick (
    .req    (pick_req),
    .last   (last),
    .winner (pick_winner),
    .valid  (pick_valid)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      bgrant   <= '0;
      msel     <= '0;
      bus_busy <= 1'b0;
      last     <= LAST_RST;
    end else begin
      state    <= state_nx;
      bgrant   <= bgrant_nx;
      msel     <= msel_nx;
      bus_busy <= busy_nx;
      last     <= last_nx;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hold_cnt <= '0;
      mask     <= '0;
      timeout  <= 1'b0;
    end else begin
      hold_cnt <= hold_nx;
      mask     <= mask_nx;
      timeout  <= timeout_nx;
    end
  end
`endif

  // A grant always passes GRANT -> RELEASE -> IDLE before the bus changes hands.
  always_comb begin
    state_nx  = state;
    bgrant_nx = bgrant;
    msel_nx   = msel;
    busy_nx   = bus_busy;
    last_nx   = last;
`ifdef ARB_TIMEOUT_EN
    hold_nx    = hold_cnt;
    mask_nx    = mask & breq;
    timeout_nx = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (pick_valid && all_ready) begin
          bgrant_nx              = '0;
          bgrant_nx[pick_winner] = 1'b1;
          msel_nx                = pick_winner;
          busy_nx                = 1'b1;
          state_nx               = GRANT;
`ifdef ARB_TIMEOUT_EN
          hold_nx                = '0;
`endif
        end
      end
      GRANT: begin
        if (!owner_req) begin
          bgrant_nx = '0;
          last_nx   = msel;
          state_nx  = RELEASE;
        end
`ifdef ARB_TIMEOUT_EN
        else if (hold_cnt == HOLD_LAST) begin
          // Watchdog revoke: the stuck owner sits out until it drops its request.
          bgrant_nx     = '0;
          last_nx       = msel;
          state_nx      = RELEASE;
          timeout_nx    = 1'b1;
          mask_nx[msel] = 1'b1;
        end else begin
          hold_nx = hold_cnt + 1'b1;
        end
`endif
      end
      RELEASE: begin
        if (all_ready) begin
          busy_nx  = 1'b0;
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx  = IDLE;
        bgrant_nx = '0;
        busy_nx   = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Directed self-checking bench for bus_rr_arbiter; the watchdog section runs
// only when built with ARB_TIMEOUT_EN (MAX_HOLD=8).
module tb_bus_rr_arbiter;

`ifdef ARB_TIMEOUT_EN
  localparam int HOLD = 8;
`else
  localparam int HOLD = 256;
`endif

  logic       clk;
  logic       rstn;
  logic [3:0] breq;
  logic [2:0] sready;
  logic [3:0] bgrant;
  logic [1:0] msel;
  logic       bus_busy;
  logic       timeout;

  int errors = 0;
  int checks = 0;

  bus_rr_arbiter #(
    .NUM_MASTERS (4),
    .NUM_SLAVES  (3),
    .MSEL_W      (2),
    .MAX_HOLD    (HOLD)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .breq     (breq),
    .sready   (sready),
    .bgrant   (bgrant),
    .msel     (msel),
    .bus_busy (bus_busy),
    .timeout  (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] req, input logic [2:0] rdy);
    breq   = req;
    sready = rdy;
  endtask

  task automatic applyReset();
    rstn = 1'b0;
    applyStimulus(4'b0000, 3'b111);
    tick();
    rstn = 1'b1;
  endtask

  int exp_order [5] = '{0, 1, 2, 3, 0};

  initial begin
    rstn = 1'b0;
    applyStimulus(4'b0000, 3'b111);
    tick();
    tick();
    checkOutput("rst_bgrant", bgrant, 4'b0000);
    checkOutput("rst_msel", msel, 2'd0);
    checkOutput("rst_busy", bus_busy, 1'b0);
    checkOutput("rst_timeout", timeout, 1'b0);
    rstn = 1'b1;

    // First grant: one cycle latency, no combinational path.
    applyStimulus(4'b0001, 3'b111);
    #1;
    checkOutput("no_comb_path", bgrant, 4'b0000);
    tick();
    checkOutput("g0_bgrant", bgrant, 4'b0001);
    checkOutput("g0_msel", msel, 2'd0);
    checkOutput("g0_busy", bus_busy, 1'b1);
    applyStimulus(4'b0000, 3'b111);
    tick();
    checkOutput("g0_rel_bgrant", bgrant, 4'b0000);
    checkOutput("g0_rel_busy", bus_busy, 1'b1);
    tick();
    checkOutput("g0_idle_busy", bus_busy, 1'b0);
    checkOutput("g0_idle_msel", msel, 2'd0);

    // Fair rotation with everyone requesting.
    applyReset();
    applyStimulus(4'b1111, 3'b111);
    for (int g = 0; g < 5; g++) begin
      tick();
      checkOutput($sformatf("rr%0d_bgrant", g), bgrant, 4'b0001 << exp_order[g]);
      checkOutput($sformatf("rr%0d_msel", g), msel, exp_order[g]);
      for (int c = 0; c < 4; c++) begin
        tick();
        checkOutput($sformatf("rr%0d_hold", g), bgrant, 4'b0001 << exp_order[g]);
      end
      checkOutput($sformatf("rr%0d_timeout", g), timeout, 1'b0);
      breq = 4'b1111 & ~(4'b0001 << exp_order[g]);
      tick();
      checkOutput($sformatf("rr%0d_rel", g), bgrant, 4'b0000);
      checkOutput($sformatf("rr%0d_rel_busy", g), bus_busy, 1'b1);
      breq = 4'b1111;
      tick();
      checkOutput($sformatf("rr%0d_idle", g), bgrant, 4'b0000);
      checkOutput($sformatf("rr%0d_idle_busy", g), bus_busy, 1'b0);
    end

    // Release stretched by a busy slave; non-owner requests ignored in GRANT.
    applyReset();
    applyStimulus(4'b0100, 3'b111);
    tick();
    checkOutput("m2_bgrant", bgrant, 4'b0100);
    applyStimulus(4'b0110, 3'b111);
    tick();
    checkOutput("m2_ignore_other", bgrant, 4'b0100);
    checkOutput("m2_ignore_msel", msel, 2'd2);
    applyStimulus(4'b0010, 3'b101);
    tick();
    checkOutput("m2_drop", bgrant, 4'b0000);
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput($sformatf("m2_wait%0d_bgrant", i), bgrant, 4'b0000);
      checkOutput($sformatf("m2_wait%0d_busy", i), bus_busy, 1'b1);
    end
    applyStimulus(4'b0010, 3'b111);
    tick();
    checkOutput("m2_idle_bgrant", bgrant, 4'b0000);
    checkOutput("m2_idle_busy", bus_busy, 1'b0);
    checkOutput("m2_idle_msel", msel, 2'd2);
    tick();
    checkOutput("m1_after_rel", bgrant, 4'b0010);
    checkOutput("m1_after_rel_msel", msel, 2'd1);

    // Asynchronous reset in the middle of a grant.
    applyReset();
    applyStimulus(4'b1000, 3'b111);
    tick();
    checkOutput("m3_bgrant", bgrant, 4'b1000);
    checkOutput("m3_msel", msel, 2'd3);
    #2;
    rstn = 1'b0;
    #1;
    checkOutput("async_rst_bgrant", bgrant, 4'b0000);
    checkOutput("async_rst_msel", msel, 2'd0);
    checkOutput("async_rst_busy", bus_busy, 1'b0);
    tick();
    rstn = 1'b1;
    applyStimulus(4'b1001, 3'b111);
    tick();
    checkOutput("post_rst_bgrant", bgrant, 4'b0001);

    // Slave not ready in IDLE blocks the grant.
    applyReset();
    applyStimulus(4'b0010, 3'b011);
    tick();
    tick();
    checkOutput("notready_bgrant", bgrant, 4'b0000);
    checkOutput("notready_busy", bus_busy, 1'b0);
    applyStimulus(4'b0010, 3'b111);
    tick();
    checkOutput("ready_bgrant", bgrant, 4'b0010);
    checkOutput("ready_msel", msel, 2'd1);

    // Sole requester drops and re-raises: it wins again after RELEASE and IDLE.
    applyStimulus(4'b0000, 3'b111);
    tick();
    checkOutput("rerise_rel", bgrant, 4'b0000);
    applyStimulus(4'b0010, 3'b111);
    tick();
    checkOutput("rerise_idle", bgrant, 4'b0000);
    tick();
    checkOutput("rerise_regrant", bgrant, 4'b0010);

`ifdef ARB_TIMEOUT_EN
    // Watchdog: master 1 holds forever, master 2 waits.
    applyReset();
    applyStimulus(4'b0010, 3'b111);
    tick();
    checkOutput("wd_grant", bgrant, 4'b0010);
    applyStimulus(4'b0110, 3'b111);
    for (int i = 0; i < 7; i++) begin
      tick();
      checkOutput($sformatf("wd_hold%0d", i), bgrant, 4'b0010);
      checkOutput($sformatf("wd_hold%0d_to", i), timeout, 1'b0);
    end
    tick();
    checkOutput("wd_revoke", bgrant, 4'b0000);
    checkOutput("wd_pulse", timeout, 1'b1);
    tick();
    checkOutput("wd_pulse_end", timeout, 1'b0);
    tick();
    checkOutput("wd_next", bgrant, 4'b0100);
    applyStimulus(4'b0010, 3'b111);
    tick();
    tick();
    tick();
    checkOutput("wd_masked", bgrant, 4'b0000);
    applyStimulus(4'b0000, 3'b111);
    tick();
    applyStimulus(4'b0010, 3'b111);
    tick();
    checkOutput("wd_unmasked", bgrant, 4'b0010);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bus_rr_arbiter.md
Name: bus_rr_arbiter

Overview:
Round-robin bus arbiter that shares the serial system bus between NUM_MASTERS masters.
- Grants one master at a time and drives the master-select mux index.
- Grants only when every slave reports ready, so a new owner never starts while a slave is still finishing the previous transaction.
- Scales to more than two masters with fair rotation; optional watchdog revokes a stuck grant.

Parameters:
NUM_MASTERS, 4, number of requesting masters (>=1).
NUM_SLAVES, 3, number of slaves whose ready flags gate arbitration.
MSEL_W, 2, width of msel; must equal max(1, clog2(NUM_MASTERS)).
MAX_HOLD, 256, grant watchdog limit in cycles; used only with ARB_TIMEOUT_EN.

Ports:
clk  in  1  system clock, rising edge.
rstn  in  1  reset, asynchronous, active-low.
breq  in  NUM_MASTERS  per-master bus request, level, held for the whole transaction.
sready  in  NUM_SLAVES  per-slave ready (1 = idle or finished).
bgrant  out  NUM_MASTERS  one-hot grant, registered.
msel  out  MSEL_W  index of current or last owner, drives the bus mux.
bus_busy  out  1  high while a grant is active or in RELEASE.
timeout  out  1  one-cycle pulse on a forced revoke (ARB_TIMEOUT_EN only, else tied 0).

Behaviour:
- Reset values, applied asynchronously on rstn low:
  - bgrant=0, msel=0, bus_busy=0, timeout=0, state=IDLE.
  - Pointer last=NUM_MASTERS-1, so master 0 has first priority.
- States: IDLE, GRANT, RELEASE.
- IDLE:
  - Grant condition: |breq and &sready. On that edge:
    - Pick the first requester scanning last+1, last+2, ... modulo NUM_MASTERS.
    - Set bgrant[winner]=1, msel=winner, bus_busy=1; go to GRANT.
  - Latency: breq sampled high at edge N gives bgrant high after edge N. One cycle, no combinational path from breq to bgrant.
  - If any sready=0, stay in IDLE and issue no grant, even if requests are pending.
- GRANT:
  - Hold bgrant and msel while breq[owner]=1. Other requests are ignored.
  - breq[owner]=0 sampled: on that edge clear bgrant, set last=owner, go to RELEASE. bus_busy stays 1.
- RELEASE:
  - Stay while any sready=0.
  - When &sready is sampled: go to IDLE and clear bus_busy.
  - Minimum time in RELEASE is one cycle, so there are at least 2 cycles from breq drop to the next grant.
- msel keeps the last owner while in IDLE; it changes only on a new grant.
- bgrant is always one-hot or zero. A grant never moves directly from one master to another without passing through RELEASE and IDLE.
- Fairness:
  - The owner is lowest priority at its next arbitration.
  - With all masters requesting continuously, grants cycle 0,1,2,3,0,...
- Boundary cases:
  - Owner drops and re-raises breq on consecutive cycles: goes through RELEASE. It re-wins only if no other master is requesting.
  - breq from a non-owner that toggles during GRANT: no effect.
  - NUM_MASTERS=1: the pointer is constant and master 0 is always chosen.
  - Reset mid-GRANT: bgrant drops immediately (asynchronous) and the pointer returns to its reset value.
  - breq bits for indices >= NUM_MASTERS do not exist; parameter check via generate error if MSEL_W is too small.

Optional Feature:
ARB_TIMEOUT_EN
- Defined:
  - A hold counter (clog2(MAX_HOLD+1) bits) clears on grant and increments each GRANT cycle.
  - When the count reaches MAX_HOLD with breq[owner] still 1: clear bgrant, pulse timeout for 1 cycle, set last=owner, go to RELEASE.
  - Set mask[owner]. A masked master is excluded from arbitration until its breq is sampled 0; mask clears on reset.
- Undefined: no counter and no mask; timeout is tied 0; the grant is held indefinitely.

Decomposition:
- Shared package bus_pkg:
  - arb_state_t enum (IDLE, GRANT, RELEASE).
  - Constants for default NUM_MASTERS, NUM_SLAVES, MAX_HOLD.
  - clog2-based width helper function.
- One sub-module, rr_pick: purely combinational rotate-priority-encoder.
  - Inputs: req vector, last index.
  - Outputs: winner index and a valid flag.
  - Instantiated once; the FSM, pointer, counter and mask stay in bus_rr_arbiter.

Test Plan:
- Reset then breq=4'b0001, sready=3'b111 -> bgrant=0001 and msel=0 one cycle later; bus_busy=1.
- breq=4'b1111 held; each owner drops breq for 1 cycle after 5 cycles of ownership -> grant order 0,1,2,3,0. No overlap; >=2 cycles between grants.
- Owner 2 drops breq while sready=3'b101 for 4 cycles -> stays in RELEASE 4 cycles, bus_busy=1, bgrant=0. Grant to the next requester 1 cycle after sready=111.
- rstn pulsed low mid-GRANT (owner 3) -> bgrant=0 and msel=0 immediately. After release, breq=1001 -> master 0 granted.
- With ARB_TIMEOUT_EN and MAX_HOLD=8: master 1 holds breq indefinitely, master 2 requesting -> timeout pulse after 8 GRANT cycles, then master 2 granted. Master 1 is not re-granted until its breq toggles 0->1.
- sready=3'b011 in IDLE with breq=0010 -> no grant. sready->111 -> bgrant=0010 next cycle.
